// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter that hands the single VGA pixel-write port to one sprite client per burst.
// Optional ARB_STATS_EN macro adds grant_count / timeout_count statistics outputs.
module sprite_draw_arbiter #(
   parameter int NUM_CLIENTS    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_CLIENTS-1:0]     client_req,
   input  logic [NUM_CLIENTS-1:0]     client_done,
   input  logic [7*NUM_CLIENTS-1:0]   client_x,
   input  logic [7*NUM_CLIENTS-1:0]   client_y,
   input  logic [3*NUM_CLIENTS-1:0]   client_c,
   input  logic [NUM_CLIENTS-1:0]     client_we,
   output logic [NUM_CLIENTS-1:0]     grant,
   output logic [6:0]                 vga_x,
   output logic [6:0]                 vga_y,
   output logic [2:0]                 vga_c,
   output logic                       vga_writeEn,
`ifdef ARB_STATS_EN
   output logic [15:0]                grant_count,
   output logic [7:0]                 timeout_count,
`endif
   output logic                       timeout_pulse
);

   // state    | meaning
   // ST_IDLE  | port free, arbitrating among requesters from rr_ptr upward
   // ST_GRANT | client gidx owns the port; its pixels are forwarded
   // ST_GAP   | one dead cycle after a burst before re-arbitrating
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

   state_t                   state_q, state_d;
   logic [1:0]               gidx_q, gidx_d;
   logic [1:0]               rr_ptr_q, rr_ptr_d;
   logic [7:0]               tcount_q, tcount_d;
   logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
   logic [6:0]               vga_x_q, vga_x_d;
   logic [6:0]               vga_y_q, vga_y_d;
   logic [2:0]               vga_c_q, vga_c_d;
   logic                     vga_we_q, vga_we_d;

   logic [3:0]               req_pad, done_pad, we_pad;
   logic [27:0]              x_pad, y_pad;
   logic [11:0]              c_pad;
   logic [6:0]               x_arr [4];
   logic [6:0]               y_arr [4];
   logic [2:0]               c_arr [4];
   logic [1:0]               sel_idx, cand;
   logic                     sel_found;
   logic                     timeout_hit;

   function automatic logic [1:0] wrap_inc(input logic [1:0] i);
      return (int'(i) == NUM_CLIENTS - 1) ? 2'd0 : i + 2'd1;
   endfunction

   // Pad every client vector to four lanes so a 2-bit index is always in range.
   always_comb begin
      req_pad  = 4'(client_req);
      done_pad = 4'(client_done);
      we_pad   = 4'(client_we);
      x_pad    = 28'(client_x);
      y_pad    = 28'(client_y);
      c_pad    = 12'(client_c);
      for (int i = 0; i < 4; i++) begin
         x_arr[i] = x_pad[7*i +: 7];
         y_arr[i] = y_pad[7*i +: 7];
         c_arr[i] = c_pad[3*i +: 3];
      end
   end

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = rr_ptr_q;
      cand      = rr_ptr_q;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         if (!sel_found && req_pad[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
         cand = wrap_inc(cand);
      end
   end

   // A done on the last allowed cycle wins over the timeout.
   assign timeout_hit = (state_q == ST_GRANT) && !done_pad[gidx_q] &&
                        (tcount_q == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      tcount_d = tcount_q;
      grant_d  = grant_q;
      vga_x_d  = vga_x_q;
      vga_y_d  = vga_y_q;
      vga_c_d  = vga_c_q;
      vga_we_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            if (sel_found) begin
               state_d  = ST_GRANT;
               gidx_d   = sel_idx;
               grant_d  = NUM_CLIENTS'(4'b0001 << sel_idx);
               tcount_d = 8'd0;
            end
         end
         ST_GRANT: begin
            vga_we_d = we_pad[gidx_q];
            if (we_pad[gidx_q]) begin
               vga_x_d = x_arr[gidx_q];
               vga_y_d = y_arr[gidx_q];
               vga_c_d = c_arr[gidx_q];
            end
            tcount_d = tcount_q + 8'd1;
            if (done_pad[gidx_q] || timeout_hit) begin
               state_d  = ST_GAP;
               grant_d  = '0;
               rr_ptr_d = wrap_inc(gidx_q);
            end
         end
         ST_GAP: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         gidx_q   <= 2'd0;
         rr_ptr_q <= 2'd0;
         tcount_q <= 8'd0;
         grant_q  <= '0;
         vga_x_q  <= 7'd0;
         vga_y_q  <= 7'd0;
         vga_c_q  <= 3'd0;
         vga_we_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
         tcount_q <= tcount_d;
         grant_q  <= grant_d;
         vga_x_q  <= vga_x_d;
         vga_y_q  <= vga_y_d;
         vga_c_q  <= vga_c_d;
         vga_we_q <= vga_we_d;
      end
   end

   assign grant         = grant_q;
   assign vga_x         = vga_x_q;
   assign vga_y         = vga_y_q;
   assign vga_c         = vga_c_q;
   assign vga_writeEn   = vga_we_q;
   assign timeout_pulse = timeout_hit;

`ifdef ARB_STATS_EN
   logic [15:0] grant_count_q, grant_count_d;
   logic [7:0]  timeout_count_q, timeout_count_d;

   always_comb begin
      grant_count_d   = grant_count_q;
      timeout_count_d = timeout_count_q;
      if (state_q == ST_IDLE && sel_found) begin
         grant_count_d = grant_count_q + 16'd1;
      end
      if (timeout_hit && timeout_count_q != 8'hFF) begin
         timeout_count_d = timeout_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         grant_count_q   <= 16'd0;
         timeout_count_q <= 8'd0;
      end else begin
         grant_count_q   <= grant_count_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign grant_count   = grant_count_q;
   assign timeout_count = timeout_count_q;
`endif

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Directed bench for sprite_draw_arbiter with two clients and a short timeout.
module tb_sprite_draw_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  client_req, client_done, client_we;
   logic [13:0] client_x, client_y;
   logic [5:0]  client_c;
   logic [1:0]  grant;
   logic [6:0]  vga_x, vga_y;
   logic [2:0]  vga_c;
   logic        vga_writeEn, timeout_pulse;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   sprite_draw_arbiter #(.NUM_CLIENTS(2), .TIMEOUT_CYCLES(20)) dut (
      .clk(clk), .resetn(resetn),
      .client_req(client_req), .client_done(client_done),
      .client_x(client_x), .client_y(client_y), .client_c(client_c),
      .client_we(client_we), .grant(grant),
      .vga_x(vga_x), .vga_y(vga_y), .vga_c(vga_c),
      .vga_writeEn(vga_writeEn), .timeout_pulse(timeout_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic set_client(input int i, input logic [6:0] x, input logic [6:0] y,
                             input logic [2:0] c, input logic we, input logic done);
      client_x[7*i +: 7] = x;
      client_y[7*i +: 7] = y;
      client_c[3*i +: 3] = c;
      client_we[i]       = we;
      client_done[i]     = done;
   endtask

   // Returns at the negedge of the first granted cycle.
   task automatic wait_grant(input logic [1:0] exp_g, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == 2'b00 && n < 10);
      chk({tag, "_grant"}, 32'(grant), 32'(exp_g));
      chk({tag, "_latency"}, n, 1);
   endtask

   // Drives npix pixels from client g while the other client streams junk.
   task automatic burst(input int g, input int npix, input int done_k,
                        input logic [6:0] bx, input logic [6:0] by, input logic [2:0] bc,
                        input bit exp_to);
      logic [1:0] oh;
      oh = 2'(1 << g);
      for (int k = 0; k < npix; k++) begin
         set_client(g, 7'(bx + 7'(k)), by, bc, 1'b1, k == done_k);
         set_client(1 - g, 7'h7f, 7'h7f, 3'h7, 1'b1, 1'b1);
         #1 chk("timeout_pulse", 32'(timeout_pulse), 32'(k == npix - 1 && exp_to));
         @(negedge clk);
         chk("vga_we", 32'(vga_writeEn), 1);
         chk("vga_x", 32'(vga_x), 32'(7'(bx + 7'(k))));
         chk("vga_y", 32'(vga_y), 32'(by));
         chk("vga_c", 32'(vga_c), 32'(bc));
         chk("burst_grant", 32'(grant), (k == npix - 1) ? 32'd0 : 32'(oh));
      end
      client_we   = 2'b00;
      client_done = 2'b00;
   endtask

   // Called at the GAP negedge: the idle cycle that follows must not write.
   task automatic after_gap(input logic [6:0] last_x);
      @(negedge clk);
      chk("gap_we", 32'(vga_writeEn), 0);
      chk("gap_hold_x", 32'(vga_x), 32'(last_x));
   endtask

   initial begin
      resetn = 1'b0;
      client_req = '0; client_done = '0; client_we = '0;
      client_x = '0; client_y = '0; client_c = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle", 32'({grant, vga_writeEn, vga_x, vga_y, vga_c}), 0);
      end

      client_req = 2'b01;
      wait_grant(2'b01, "solo0");
      burst(0, 16, 15, 7'd10, 7'd20, 3'b110, 1'b0);
      client_req = 2'b00;
      after_gap(7'd25);

      client_req = 2'b11;
      for (int b = 0; b < 4; b++) begin
         wait_grant((b % 2 == 0) ? 2'b10 : 2'b01, "alt");
         burst((b % 2 == 0) ? 1 : 0, 16, 15, 7'(30 + 20*b), 7'(b), 3'(b + 1), 1'b0);
         after_gap(7'(45 + 20*b));
      end

      client_req = 2'b10;
      wait_grant(2'b10, "to1");
      burst(1, 20, -1, 7'd5, 7'd5, 3'b011, 1'b1);
      client_req = 2'b11;
      after_gap(7'd24);
      wait_grant(2'b01, "after_to");
      burst(0, 20, 19, 7'd40, 7'd50, 3'b101, 1'b0);
      after_gap(7'd59);

      wait_grant(2'b10, "pre_rst");
      for (int k = 0; k < 8; k++) begin
         set_client(1, 7'(100 + k), 7'd9, 3'b111, 1'b1, 1'b0);
         if (k == 7) resetn = 1'b0;
         @(negedge clk);
      end
      chk("rst_grant", 32'(grant), 0);
      chk("rst_we", 32'(vga_writeEn), 0);
      chk("rst_xyc", 32'({vga_x, vga_y, vga_c}), 0);
      chk("rst_to", 32'(timeout_pulse), 0);
      client_we = 2'b00;
      resetn = 1'b1;
      wait_grant(2'b01, "post_rst");

      client_req = 2'b00;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
